// File: rtl/demod_if.sv
// rtl/demod_if.sv - sample-in / bit-out stream bundle for the 16QAM demodulator
// Purpose: groups the modulated-sample input stream and the serial bit output
//          handshake of demod_top into one bundle.
// Signals:
//   sample       signed 8-bit modulated sample          (master -> slave)
//   sample_valid sample is accepted this cycle          (master -> slave)
//   sym_sync     first sample of a symbol               (master -> slave)
//   bit_out      serial data bit                        (slave  -> master)
//   bit_valid    bit_out holds a bit                    (slave  -> master)
//   bit_ready    sink accepts bit_out when bit_valid    (master -> slave)
interface demod_if;
  logic signed [7:0] sample;
  logic              sample_valid;
  logic              sym_sync;
  logic              bit_out;
  logic              bit_valid;
  logic              bit_ready;

  modport master (output sample, sample_valid, sym_sync, bit_ready,
                  input  bit_out, bit_valid);
  modport slave  (input  sample, sample_valid, sym_sync, bit_ready,
                  output bit_out, bit_valid);
endinterface

// File: rtl/demod_top.sv
// rtl/demod_top.sv - coherent 16QAM demodulator with serial bit output
// Purpose: mixes the sample stream with a local cos/sin oscillator, integrates
//          each channel over one symbol, slices to 2-bit I/Q decisions and
//          re-serialises them (I msb, I lsb, Q msb, Q lsb) on a valid/ready port.
// Ports:
//   clk          sample-rate clock
//   rst          synchronous active-high reset
//   io           demod_if.slave: sample stream in, bit stream out
//   sym_i_o      last decided I symbol
//   sym_q_o      last decided Q symbol
//   sym_valid_o  one-cycle pulse when sym_i_o/sym_q_o update
//   overflow_o   sticky: a decided symbol was dropped
module demod_top #(
  parameter int SPS            = 32,
  parameter int CARRIER_PERIOD = 16,
  parameter int AMP            = 16,
  parameter int THRESH         = AMP * 127 * SPS
) (
  input  logic       clk,
  input  logic       rst,
  demod_if.slave     io,
  output logic [1:0] sym_i_o,
  output logic [1:0] sym_q_o,
  output logic       sym_valid_o,
  output logic       overflow_o
);
  localparam int KW = (CARRIER_PERIOD > 1) ? $clog2(CARRIER_PERIOD) : 1;
  localparam int CW = (SPS > 1) ? $clog2(SPS) : 1;
  localparam int AW = 16 + CW;
  localparam logic signed [AW-1:0] TH_P = AW'(THRESH);
  localparam logic signed [AW-1:0] TH_N = AW'(-THRESH);

  typedef enum logic {S_IDLE = 1'b0, S_INTEG = 1'b1} state_e;

  // 16-phase cosine table; sine is the same table a quarter period later.
  function automatic logic signed [7:0] cos_lut(input logic [3:0] ph);
    case (ph)
      4'd0:           cos_lut = 8'sd127;
      4'd1,  4'd15:   cos_lut = 8'sd117;
      4'd2,  4'd14:   cos_lut = 8'sd90;
      4'd3,  4'd13:   cos_lut = 8'sd49;
      4'd5,  4'd11:   cos_lut = -8'sd49;
      4'd6,  4'd10:   cos_lut = -8'sd90;
      4'd7,  4'd9:    cos_lut = -8'sd117;
      4'd8:           cos_lut = -8'sd127;
      default:        cos_lut = 8'sd0;
    endcase
  endfunction

  function automatic logic [1:0] slice(input logic signed [AW-1:0] a);
    if (a >= TH_P)        slice = 2'b11;
    else if (!a[AW-1])    slice = 2'b10;
    else if (a >= TH_N)   slice = 2'b01;
    else                  slice = 2'b00;
  endfunction

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d, k_cur;
  logic [CW-1:0] cnt_q, cnt_d, cnt_eff;
  logic          acc_en, smp_first, smp_last;
  logic [3:0]    lo_idx;
  logic signed [15:0] s_ext, c_ext, n_ext;

  logic               p_valid_q, p_first_q, p_last_q;
  logic signed [15:0] pi_q, pq_q;
  logic signed [AW-1:0] acc_i_q, acc_q_q, pi_ext, pq_ext;
  logic               a_last_q;
  logic [1:0]         sym_i_q, sym_q_q;
  logic               sym_valid_q, overflow_q, overflow_d;

  logic [3:0] sh_q, sh_d, hold_q, hold_d;
  logic [2:0] sh_cnt_q, sh_cnt_d;
  logic       hold_full_q, hold_full_d, fire;

  // Oscillator phase: a sync sample is mixed at phase 0.
  assign k_cur  = io.sym_sync ? '0 : k_q;
  assign k_d    = !io.sample_valid ? k_q :
                  (k_cur == KW'(CARRIER_PERIOD - 1)) ? '0 : k_cur + 1'b1;
  assign lo_idx = 4'((32'(k_cur) * 32'd16) / 32'(CARRIER_PERIOD));
  assign s_ext  = 16'($signed(io.sample));
  assign c_ext  = 16'(cos_lut(lo_idx));
  assign n_ext  = 16'(cos_lut(lo_idx - 4'd4));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_en    = 1'b0;
    smp_first = 1'b0;
    smp_last  = 1'b0;
    cnt_eff   = io.sym_sync ? '0 : cnt_q;
    case (state_q)
      S_IDLE: begin
        if (io.sample_valid && io.sym_sync) begin
          state_d = S_INTEG;
          acc_en  = 1'b1;
        end
      end
      S_INTEG: begin
        acc_en = io.sample_valid;
      end
      default: state_d = S_IDLE;
    endcase
    if (acc_en) begin
      // sync mid-symbol restarts at count 0, dropping the partial sum
      smp_first = (cnt_eff == '0);
      smp_last  = (cnt_eff == CW'(SPS - 1));
      cnt_d     = smp_last ? '0 : cnt_eff + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pi_ext = {{(AW-16){pi_q[15]}}, pi_q};
  assign pq_ext = {{(AW-16){pq_q[15]}}, pq_q};

  // Mixer -> integrator -> slicer, one register stage each.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_valid_q   <= 1'b0;
      p_first_q   <= 1'b0;
      p_last_q    <= 1'b0;
      pi_q        <= '0;
      pq_q        <= '0;
      acc_i_q     <= '0;
      acc_q_q     <= '0;
      a_last_q    <= 1'b0;
      sym_i_q     <= 2'b00;
      sym_q_q     <= 2'b00;
      sym_valid_q <= 1'b0;
    end else begin
      p_valid_q <= acc_en;
      p_first_q <= smp_first;
      p_last_q  <= smp_last;
      if (acc_en) begin
        pi_q <= s_ext * c_ext;
        pq_q <= s_ext * n_ext;
      end
      if (p_valid_q) begin
        acc_i_q <= p_first_q ? pi_ext : acc_i_q + pi_ext;
        acc_q_q <= p_first_q ? pq_ext : acc_q_q + pq_ext;
      end
      a_last_q    <= p_valid_q && p_last_q;
      sym_valid_q <= a_last_q;
      if (a_last_q) begin
        sym_i_q <= slice(acc_i_q);
        sym_q_q <= slice(acc_q_q);
      end
    end
  end

  assign fire = (sh_cnt_q != 3'd0) && io.bit_ready;

  // Serializer: shift first, then refill from hold on the last bit, then
  // place a new decision into whichever slot is free after those moves.
  always_comb begin
    sh_d        = sh_q;
    sh_cnt_d    = sh_cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    overflow_d  = overflow_q;
    if (fire) begin
      sh_d     = {sh_q[2:0], 1'b0};
      sh_cnt_d = sh_cnt_q - 3'd1;
    end
    if (fire && (sh_cnt_q == 3'd1) && hold_full_q) begin
      sh_d        = hold_q;
      sh_cnt_d    = 3'd4;
      hold_full_d = 1'b0;
    end
    if (sym_valid_q) begin
      if (sh_cnt_d == 3'd0) begin
        sh_d     = {sym_i_q, sym_q_q};
        sh_cnt_d = 3'd4;
      end else if (!hold_full_d) begin
        hold_d      = {sym_i_q, sym_q_q};
        hold_full_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q        <= '0;
      sh_cnt_q    <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      sh_q        <= sh_d;
      sh_cnt_q    <= sh_cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      overflow_q  <= overflow_d;
    end
  end

  assign io.bit_out   = sh_q[3];
  assign io.bit_valid = (sh_cnt_q != 3'd0);
  assign sym_i_o      = sym_i_q;
  assign sym_q_o      = sym_q_q;
  assign sym_valid_o  = sym_valid_q;
  assign overflow_o   = overflow_q;
endmodule

// File: tb/tb_demod_top.sv
// tb/tb_demod_top.sv - directed self-checking bench for demod_top
module tb_demod_top;
  localparam int SPS = 32;
  localparam int P   = 16;
  localparam int AMP = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sym_i, sym_q;
  logic       sym_valid, overflow;
  demod_if    io ();

  demod_top #(.SPS(SPS), .CARRIER_PERIOD(P), .AMP(AMP)) dut (
    .clk(clk), .rst(rst), .io(io),
    .sym_i_o(sym_i), .sym_q_o(sym_q),
    .sym_valid_o(sym_valid), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int cos_t [16] = '{127, 117, 90, 49, 0, -49, -90, -117, -127, -117, -90, -49, 0, 49, 90, 117};
  int sin_t [16] = '{0, 49, 90, 117, 127, 117, 90, 49, 0, -49, -90, -117, -127, -117, -90, -49};

  int         sv_cyc[$];
  logic [3:0] sv_sym[$];
  logic       bit_val[$];
  int         bit_cyc[$];

  always @(negedge clk) begin
    if (sym_valid === 1'b1) begin
      sv_cyc.push_back(cyc);
      sv_sym.push_back({sym_i, sym_q});
    end
    if (io.bit_valid === 1'b1 && io.bit_ready === 1'b1) begin
      bit_val.push_back(io.bit_out);
      bit_cyc.push_back(cyc);
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sym_at(input int j);
    if (j < sv_sym.size()) return int'(sv_sym[j]);
    return -1;
  endfunction
  function automatic int svc_at(input int j);
    if (j < sv_cyc.size()) return sv_cyc[j];
    return -1;
  endfunction
  function automatic int bit_at(input int j);
    if (j < bit_val.size()) return int'(bit_val[j]);
    return -1;
  endfunction
  function automatic int bitc_at(input int j);
    if (j < bit_cyc.size()) return bit_cyc[j];
    return -1;
  endfunction

  task automatic clear_log();
    sv_cyc.delete(); sv_sym.delete(); bit_val.delete(); bit_cyc.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic signed [7:0] s, input logic sync);
    io.sample = s; io.sample_valid = 1'b1; io.sym_sync = sync;
    step();
  endtask

  task automatic idle(input int n);
    io.sample = '0; io.sample_valid = 1'b0; io.sym_sync = 1'b0;
    repeat (n) step();
  endtask

  function automatic logic signed [7:0] mod_sample(input logic [1:0] si, input logic [1:0] sq, input int k);
    int li, lq, num, r;
    li  = 2 * int'(si) - 3;
    lq  = 2 * int'(sq) - 3;
    num = li * AMP * cos_t[k] + lq * AMP * sin_t[k];
    r   = (num >= 0) ? (num + 63) / 127 : -((-num + 63) / 127);
    return 8'(r);
  endfunction

  // Hand-built sample sets giving acc_i = THRESH, 0, -THRESH, -THRESH-1.
  function automatic logic signed [7:0] bnd_sample(input int pat, input int n);
    int s;
    case (n)
      0, 16:   s = 127;
      8, 24:   s = -127;
      1:       s = 1;
      2:       s = -6;
      3:       s = 19;
      default: s = 0;
    endcase
    if (pat == 1) s = 0;
    if (pat >= 2) s = -s;
    if (pat == 3) begin
      if (n == 18) s = -6;
      if (n == 19) s = 11;
    end
    return 8'(s);
  endfunction

  task automatic send_symbol(input logic [1:0] si, input logic [1:0] sq, input int pat,
                             input logic sync_first, input int nsamp);
    for (int n = 0; n < nsamp; n++) begin
      if (pat < 0) drive(mod_sample(si, sq, n % P), sync_first && (n == 0));
      else         drive(bnd_sample(pat, n), sync_first && (n == 0));
    end
  endtask

  task automatic check_bits(input string name, input int base, input logic [3:0] sym4);
    for (int b = 0; b < 4; b++) check(name, bit_at(base + b), int'(sym4[3 - b]));
  endtask

  typedef struct {
    logic [1:0] in_i;
    logic [1:0] in_q;
    int         pat;
    logic [1:0] exp_i;
    logic [1:0] exp_q;
  } vec_t;

  vec_t vecs[20];

  initial begin
    int t0;
    int d;
    logic [3:0] e;

    for (int m = 0; m < 16; m++)
      vecs[m] = '{2'(m >> 2), 2'(m & 3), -1, 2'(m >> 2), 2'(m & 3)};
    vecs[16] = '{2'b00, 2'b00, 0, 2'b11, 2'b10};
    vecs[17] = '{2'b00, 2'b00, 1, 2'b10, 2'b10};
    vecs[18] = '{2'b00, 2'b00, 2, 2'b01, 2'b01};
    vecs[19] = '{2'b00, 2'b00, 3, 2'b00, 2'b01};

    io.sample = '0; io.sample_valid = 1'b0; io.sym_sync = 1'b0; io.bit_ready = 1'b1;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    check("rst_sym_i", sym_i, 0);
    check("rst_sym_q", sym_q, 0);
    check("rst_sym_valid", sym_valid, 0);
    check("rst_bit_out", io.bit_out, 0);
    check("rst_bit_valid", io.bit_valid, 0);
    check("rst_overflow", overflow, 0);

    // single symbol I=+3, Q=-3
    clear_log();
    t0 = cyc;
    send_symbol(2'b11, 2'b00, -1, 1'b1, SPS);
    idle(12);
    check("single_count", sv_sym.size(), 1);
    check("single_sym", sym_at(0), 4'b1100);
    check("single_cyc", svc_at(0), t0 + SPS - 1 + 3);
    check("single_nbits", bit_val.size(), 4);
    check_bits("single_bit", 0, 4'b1100);
    for (int b = 0; b < 4; b++) check("single_bit_cyc", bitc_at(b), t0 + SPS - 1 + 4 + b);

    // table: all 16 symbols plus slicer boundaries, back-to-back
    clear_log();
    t0 = cyc;
    for (int v = 0; v < 20; v++)
      send_symbol(vecs[v].in_i, vecs[v].in_q, vecs[v].pat, v == 0, SPS);
    idle(12);
    check("sweep_count", sv_sym.size(), 20);
    check("sweep_nbits", bit_val.size(), 80);
    for (int v = 0; v < 20; v++) begin
      e = {vecs[v].exp_i, vecs[v].exp_q};
      check($sformatf("sweep_sym%0d", v), sym_at(v), int'(e));
      check($sformatf("sweep_cyc%0d", v), svc_at(v), t0 + SPS * v + SPS - 1 + 3);
      check_bits($sformatf("sweep_bits%0d", v), 4 * v, e);
    end
    check("sweep_overflow", overflow, 0);

    // decision coinciding with the shifter's last bit while hold is full
    clear_log();
    io.bit_ready = 1'b0;
    t0 = cyc;
    d  = t0 + 3 * SPS - 1 + 3;
    fork
      begin
        while (cyc < d - 3) step();
        io.bit_ready = 1'b1;
        while (cyc < d + 1) step();
        io.bit_ready = 1'b0;
        while (cyc < d + 6) step();
        io.bit_ready = 1'b1;
      end
    join_none
    send_symbol(2'b10, 2'b01, -1, 1'b1, SPS);
    send_symbol(2'b01, 2'b11, -1, 1'b0, SPS);
    send_symbol(2'b11, 2'b00, -1, 1'b0, SPS);
    idle(30);
    check("coin_overflow", overflow, 0);
    check("coin_nbits", bit_val.size(), 12);
    check_bits("coin_bitsA", 0, 4'b1001);
    check_bits("coin_bitsB", 4, 4'b0111);
    check_bits("coin_bitsC", 8, 4'b1100);
    check("coin_lastA_cyc", bitc_at(3), d);
    check("coin_firstB_cyc", bitc_at(4), d + 6);
    check("coin_lastC_cyc", bitc_at(11), d + 13);

    // backpressure: third symbol dropped
    clear_log();
    io.bit_ready = 1'b0;
    send_symbol(2'b01, 2'b10, -1, 1'b1, SPS);
    send_symbol(2'b10, 2'b01, -1, 1'b0, SPS);
    send_symbol(2'b11, 2'b11, -1, 1'b0, SPS);
    idle(10);
    check("bp_count", sv_sym.size(), 3);
    check("bp_overflow", overflow, 1);
    check("bp_nobits", bit_val.size(), 0);
    io.bit_ready = 1'b1;
    idle(15);
    check("bp_nbits", bit_val.size(), 8);
    check_bits("bp_bits1", 0, 4'b0110);
    check_bits("bp_bits2", 4, 4'b1001);
    check("bp_contig", bitc_at(7) - bitc_at(0), 7);
    check("bp_overflow_sticky", overflow, 1);

    // reset mid-symbol and mid-serialisation
    clear_log();
    io.bit_ready = 1'b0;
    send_symbol(2'b11, 2'b10, -1, 1'b1, SPS);
    send_symbol(2'b00, 2'b00, -1, 1'b0, 10);
    check("pre_rst_bit_valid", io.bit_valid, 1);
    rst = 1'b1;
    drive(8'sd20, 1'b0);
    drive(8'sd20, 1'b0);
    rst = 1'b0;
    check("mid_rst_sym_i", sym_i, 0);
    check("mid_rst_sym_q", sym_q, 0);
    check("mid_rst_sym_valid", sym_valid, 0);
    check("mid_rst_bit_out", io.bit_out, 0);
    check("mid_rst_bit_valid", io.bit_valid, 0);
    check("mid_rst_overflow", overflow, 0);
    io.bit_ready = 1'b1;
    clear_log();
    send_symbol(2'b01, 2'b01, -1, 1'b0, 40);
    idle(8);
    check("post_rst_nosym", sv_sym.size(), 0);
    check("post_rst_nobits", bit_val.size(), 0);
    clear_log();
    t0 = cyc;
    send_symbol(2'b10, 2'b11, -1, 1'b1, SPS);
    idle(12);
    check("post_rst_count", sv_sym.size(), 1);
    check("post_rst_sym", sym_at(0), 4'b1011);
    check("post_rst_cyc", svc_at(0), t0 + SPS - 1 + 3);

    // resync at cnt=10
    clear_log();
    send_symbol(2'b00, 2'b00, -1, 1'b1, 10);
    t0 = cyc;
    send_symbol(2'b11, 2'b11, -1, 1'b1, SPS);
    idle(12);
    check("resync_count", sv_sym.size(), 1);
    check("resync_sym", sym_at(0), 4'b1111);
    check("resync_cyc", svc_at(0), t0 + SPS - 1 + 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/demod_top.md
# demod_top

Coherent 16QAM demodulator, the receive-side counterpart of the modulator top. It takes the signed 8-bit modulated sample stream and mixes it with a local cos/sin oscillator. Each channel is integrated over one symbol period and sliced to 2-bit I/Q symbols. The recovered symbols are re-serialised into a bit stream with a valid/ready handshake.

## Interface
- SPS, 32: samples per symbol; must be a multiple of CARRIER_PERIOD.
- CARRIER_PERIOD, 16: samples per local-oscillator cycle.
- AMP, 16: mod_out amplitude per unit symbol level (levels ±1, ±3).
- THRESH, AMP*127*SPS: outer slicer threshold on the integrator value.
- clk  in  1  sole clock; sample rate.
- rst  in  1  synchronous, active-high reset.
- sample  in  8  signed modulated sample.
- sample_valid  in  1  sample is accepted this cycle.
- sym_sync  in  1  qualified by sample_valid; marks the first sample of a symbol.
- sym_i  out  2  last decided I symbol.
- sym_q  out  2  last decided Q symbol.
- sym_valid  out  1  one-cycle pulse when sym_i/sym_q update.
- bit_out  out  1  serial data bit.
- bit_valid  out  1  bit_out holds a bit.
- bit_ready  in  1  sink accepts bit_out when bit_valid && bit_ready.
- overflow  out  1  sticky; set when a decided symbol is dropped.

## Operation
- Symbol mapping: 00→-3, 01→-1, 10→+1, 11→+3.
- Bit order per symbol, first to last: sym_i[1], sym_i[0], sym_q[1], sym_q[0].
- Local oscillator:
  - Phase counter k runs 0..CARRIER_PERIOD-1 and advances on each accepted sample.
  - k is forced to 0 on a sample with sym_sync.
  - lo_cos = round(127·cos(2πk/P)), lo_sin = round(127·sin(2πk/P)), both signed 8-bit constant tables.
- Mixer: pi = sample·lo_cos, pq = sample·lo_sin, each 16-bit signed, registered.
- Integrators acc_i and acc_q:
  - Width 16+clog2(SPS), signed.
  - The first product of a symbol loads the accumulator; subsequent products add.
  - Sample counter cnt runs 0..SPS-1.
- FSM states:
  - IDLE: discards samples until sample_valid && sym_sync, then moves to INTEG with cnt=0.
  - INTEG: accumulates each accepted sample.
  - When the SPS-th sample has been accumulated, the acc values are copied to the slicer and the symbol completes. The next accepted sample starts a new symbol (cnt=0) without returning to IDLE.
  - sym_sync in INTEG with cnt≠0 discards the partial symbol; no sym_valid is produced for it, and the sync sample starts a new symbol.
- Slicer, per channel, on acc value a:
  - a ≥ THRESH → 11
  - 0 ≤ a < THRESH → 10
  - -THRESH ≤ a < 0 → 01
  - a < -THRESH → 00
- Serializer:
  - A 4-bit shift register with a bit counter, plus a one-symbol hold register.
  - On decision, the symbol loads the shifter if it is empty. Otherwise it goes to the hold register if that is empty. Otherwise it is dropped and overflow is set.
  - The hold register moves to the shifter in the cycle the shifter's last bit transfers, so there is no bubble.
  - bit_valid = shifter non-empty; bit_out = current MSB.
- overflow clears only on rst.

## Timing
- Reset: sym_i=00, sym_q=00, sym_valid=0, bit_out=0, bit_valid=0, overflow=0.
  - Reset also clears FSM (to IDLE), k, cnt, accumulators, shifter and hold register.
  - rst mid-symbol or mid-serialisation discards all in-flight data.
- Sample accepted at cycle t: product registered at t+1, accumulated at t+2.
- sym_valid pulses at t+3, where t is the cycle the SPS-th sample was accepted; sym_i/sym_q change in that same cycle.
- Serializer load happens in the sym_valid cycle, so bit_valid is first high at t+4.
- With bit_ready held 1, one bit is transferred per cycle.
- Back-to-back symbols with continuous sample_valid: sym_valid every SPS cycles; no samples lost.
- Gaps in sample_valid stall k and cnt; the pipeline still advances.
- Simultaneous events:
  - Symbol decision with the last bit transferring: the shifter reloads from the hold register and the new symbol enters the hold register.
  - Decision while the shifter is full but the hold register has just moved out that cycle: accepted, no overflow.

## Test plan
- Reset: assert rst 2 cycles mid-stream → all outputs 0 the next cycle; the next sym_valid occurs only after a fresh sym_sync plus SPS samples.
- Single symbol: bench sends sample = round((3·AMP·lo_cos + (-3)·AMP·lo_sin)/127) for 32 samples with sym_sync on the first → sym_i=11, sym_q=00, sym_valid at t+3; bits 1,1,0,0 on consecutive cycles.
- Sweep all 16 symbols back-to-back with bit_ready=1 → sym_valid every 32 cycles, each decision matches, 64 bits in the specified order, overflow=0.
- Backpressure: bit_ready=0 across 3 symbols → first in shifter, second in hold, third dropped, overflow=1. Release bit_ready → 8 bits of symbols 1 and 2 delivered.
- Resync: sym_sync at cnt=10 → no sym_valid for the partial symbol; the next sym_valid comes 32 accepted samples after the resync.
- Slicer boundaries: inject an accumulator-equivalent stimulus with acc = THRESH, 0, -THRESH, -THRESH-1 → 11, 10, 01, 00.
